// File: rtl/prng_hex_uart.sv
// Sends a captured 64-bit PRNG word over 8N1 UART as 16 uppercase hex characters plus CR/LF.
// Requests that arrive while a frame is in flight are counted in a saturating drop counter.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | line idle high, ready to capture a word
// S_START | start bit (0) of the current byte
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit (1); then next byte or back to idle
module prng_hex_uart #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_valid,
    input  logic [31:0] io_prngHigh,
    input  logic [31:0] io_prngLow,
    output logic        io_ready,
    output logic        io_tx,
    output logic [7:0]  io_dropCount
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0] BYTE_LAST = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [4:0]       byte_idx_q, byte_idx_d;
    logic [63:0]      word_q, word_d;
    logic [7:0]       drop_q, drop_d;

    logic        bit_done;
    logic [63:0] word_sh;
    logic [3:0]  nib;
    logic [7:0]  cur_byte;

    // Byte being serialised, selected from the held word by byte index
    always_comb begin
        word_sh = word_q << {byte_idx_q, 2'b00};
        nib     = word_sh[63:60];
        if (byte_idx_q == 5'd16) begin
            cur_byte = 8'h0D;
        end else if (byte_idx_q == BYTE_LAST) begin
            cur_byte = 8'h0A;
        end else if (nib < 4'd10) begin
            cur_byte = {4'h3, nib};
        end else begin
            cur_byte = 8'h37 + {4'h0, nib};
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        drop_d     = drop_q;
        io_tx      = 1'b1;
        io_ready   = 1'b0;
        bit_done   = (clk_cnt_q == '0);

        if (io_valid && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_done ? BIT_LAST : clk_cnt_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                io_ready = 1'b1;
                if (io_valid) begin
                    word_d     = {io_prngHigh, io_prngLow};
                    byte_idx_d = 5'd0;
                    bit_idx_d  = 3'd0;
                    clk_cnt_d  = BIT_LAST;
                    state_d    = S_START;
                end
            end
            S_START: begin
                io_tx = 1'b0;
                if (bit_done) begin
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                io_tx = cur_byte[bit_idx_q];
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (byte_idx_q == BYTE_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 5'd1;
                        state_d    = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 5'd0;
            word_q     <= 64'd0;
            drop_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            drop_q     <= drop_d;
        end
    end

    assign io_dropCount = drop_q;

endmodule

// File: tb/tb_prng_hex_uart.sv
// Bench for prng_hex_uart at CLKS_PER_BIT=4: every line cycle is compared with the
// bit expected from the hex/CR/LF text of the accepted word.
module tb_prng_hex_uart;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_valid;
    logic [31:0] io_prngHigh;
    logic [31:0] io_prngLow;
    logic        io_ready;
    logic        io_tx;
    logic [7:0]  io_dropCount;

    int checks   = 0;
    int errors   = 0;
    int exp_drop = 0;

    localparam int CPB   = 4;
    localparam int FRAME = 18 * 10 * CPB;

    prng_hex_uart #(.CLK_HZ(4), .BAUD(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .io_valid    (io_valid),
        .io_prngHigh (io_prngHigh),
        .io_prngLow  (io_prngLow),
        .io_ready    (io_ready),
        .io_tx       (io_tx),
        .io_dropCount(io_dropCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Character k of the frame text for word w
    function automatic logic [7:0] frame_char(input logic [63:0] w, input int k);
        string hexdig;
        int    nib;
        hexdig = "0123456789ABCDEF";
        if (k == 16) return 8'h0D;
        if (k == 17) return 8'h0A;
        nib = int'((w >> (60 - 4 * k)) & 64'hF);
        return hexdig[nib];
    endfunction

    // Expected line level c cycles after acceptance (c = 1 is the first start-bit cycle)
    function automatic logic exp_bit(input logic [63:0] w, input int c);
        int         b, k, pos;
        logic [7:0] ch;
        b   = (c - 1) / CPB;
        k   = b / 10;
        pos = b % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        ch = frame_char(w, k);
        return ch[pos - 1];
    endfunction

    // mode 0 plain, 1 inputs zeroed mid-frame, 2 three busy pulses, 3 valid held through
    // the frame and into the next, 4 valid held until the last busy cycle, 5 300 busy cycles
    task automatic frame(input logic [63:0] w, input int mode, input int abort_c);
        chk("ready_before_accept", io_ready, 1);
        io_valid    = 1'b1;
        io_prngHigh = w[63:32];
        io_prngLow  = w[31:0];
        case (mode)
            2: exp_drop += 3;
            3: exp_drop += FRAME;
            4: exp_drop += FRAME - 1;
            5: exp_drop += 300;
            default: ;
        endcase
        if (exp_drop > 255) exp_drop = 255;
        @(posedge clk); #1;
        if (mode != 3 && mode != 4) io_valid = 1'b0;
        for (int c = 1; c <= FRAME; c++) begin
            chk("tx_bit", io_tx, exp_bit(w, c));
            chk("ready_busy", io_ready, 0);
            if (c == abort_c) return;
            case (mode)
                1: if (c == 100) begin io_prngHigh = 32'd0; io_prngLow = 32'd0; end
                2: io_valid = (c >= 200 && c <= 202);
                4: io_valid = (c < FRAME);
                5: io_valid = (c >= 10 && c <= 309);
                default: ;
            endcase
            @(posedge clk); #1;
        end
        chk("ready_after_frame", io_ready, 1);
        chk("drop_count", io_dropCount, exp_drop);
    endtask

    initial begin
        reset       = 1'b0;
        io_valid    = 1'b0;
        io_prngHigh = 32'd0;
        io_prngLow  = 32'd0;
        #1;
        chk("reset_tx", io_tx, 1);
        chk("reset_ready", io_ready, 1);
        chk("reset_drop", io_dropCount, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        frame(64'h0123456789ABCDEF, 0, 0);
        @(posedge clk); #1;
        frame(64'hFEDCBA9876543210, 1, 0);
        frame({$urandom, $urandom}, 2, 0);
        frame({$urandom, $urandom}, 5, 0);
        frame(64'hFFFFFFFFFFFFFFFF, 3, 0);
        frame(64'h0000000000000000, 4, 0);
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            frame({$urandom, $urandom}, 0, 0);
        end

        // Abort during byte 5 data bits; the line is low there for a '0' character
        frame(64'h0, 0, 174);
        reset = 1'b0;
        #1;
        chk("abort_tx", io_tx, 1);
        chk("abort_ready", io_ready, 1);
        chk("abort_drop", io_dropCount, 0);
        exp_drop = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        frame({$urandom, $urandom}, 0, 0);
        frame({$urandom, $urandom}, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
